// File: rtl/game_pkg.sv
// Shared game types: shot FSM states and ammo defaults.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_RESULT   = 2'd2,
        ST_COOLDOWN = 2'd3
    } shot_state_e;

    localparam int AMMO_MAX_DEF = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mouse_shot_ctrl.sv
// Mouse-driven shot controller: button edge detect, ammo, hit-detector
// request/ack handshake with frame timeout, and post-shot cooldown.
module mouse_shot_ctrl
    import game_pkg::*;
#(
    parameter int AMMO_MAX        = AMMO_MAX_DEF,
    parameter int COOLDOWN_FRAMES = 10,
    parameter int TIMEOUT_FRAMES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] xpos_in,
    input  logic [9:0] ypos_in,
    input  logic       mouse_left_in,
    input  logic       frame_tick,
    input  logic       reload_in,
    input  logic       hit_ack,
    input  logic       hit_in,
    output logic       shot_req,
    output logic [9:0] shot_x,
    output logic [9:0] shot_y,
    output logic       hit_pulse,
    output logic       miss_pulse,
    output logic [1:0] ammo,
    output logic       busy
);

    localparam int CNT_MAX = max_int(COOLDOWN_FRAMES, TIMEOUT_FRAMES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [1:0]       AMMO_FULL = 2'(AMMO_MAX);

    shot_state_e      state;
    logic [CNT_W-1:0] frame_cnt;
    logic             btn_cur;
    logic             btn_prev;
    logic             armed;
    logic             result_hit;
    logic             press;

    // armed stays low until the raw button is seen released after reset
    assign press = btn_cur & ~btn_prev & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_cur  <= 1'b0;
            btn_prev <= 1'b0;
            armed    <= 1'b0;
        end else begin
            btn_cur  <= mouse_left_in;
            btn_prev <= btn_cur;
            armed    <= armed | ~mouse_left_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            frame_cnt  <= '0;
            ammo       <= AMMO_FULL;
            shot_x     <= '0;
            shot_y     <= '0;
            result_hit <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (reload_in) begin
                        ammo <= AMMO_FULL;
                    end else if (press && ammo != 2'd0) begin
                        shot_x    <= xpos_in;
                        shot_y    <= ypos_in;
                        ammo      <= ammo - 2'd1;
                        frame_cnt <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (hit_ack) begin
                        result_hit <= hit_in;
                        state      <= ST_RESULT;
                    end else if (frame_tick) begin
                        if (frame_cnt == TO_LAST) begin
                            result_hit <= 1'b0;
                            state      <= ST_RESULT;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                ST_RESULT: begin
                    frame_cnt <= '0;
                    state     <= ST_COOLDOWN;
                end
                ST_COOLDOWN: begin
                    if (frame_tick) begin
                        if (frame_cnt == CD_LAST) begin
                            frame_cnt <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign shot_req   = (state == ST_REQ);
    assign hit_pulse  = (state == ST_RESULT) &  result_hit;
    assign miss_pulse = (state == ST_RESULT) & ~result_hit;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_mouse_shot_ctrl.sv
// Directed bench for mouse_shot_ctrl with hand-computed expectations.
module tb_mouse_shot_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] xpos_in;
    logic [9:0] ypos_in;
    logic       mouse_left_in;
    logic       frame_tick;
    logic       reload_in;
    logic       hit_ack;
    logic       hit_in;
    logic       shot_req;
    logic [9:0] shot_x;
    logic [9:0] shot_y;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [1:0] ammo;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mouse_shot_ctrl dut (
        .clk(clk),
        .rst(rst),
        .xpos_in(xpos_in),
        .ypos_in(ypos_in),
        .mouse_left_in(mouse_left_in),
        .frame_tick(frame_tick),
        .reload_in(reload_in),
        .hit_ack(hit_ack),
        .hit_in(hit_in),
        .shot_req(shot_req),
        .shot_x(shot_x),
        .shot_y(shot_y),
        .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse),
        .ammo(ammo),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // release, then press; after this the shot (if any) is in REQ
    task automatic press_fire();
        mouse_left_in = 1'b0;
        step();
        step();
        mouse_left_in = 1'b1;
        step();
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        xpos_in = 10'd320;
        ypos_in = 10'd240;
        mouse_left_in = 1'b0;
        frame_tick = 1'b0;
        reload_in = 1'b0;
        hit_ack = 1'b0;
        hit_in = 1'b0;
        step();
        chk("rst_ammo", 32'(ammo), 3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req", 32'(shot_req), 0);
        rst = 1'b0;
        step();

        // shot 1: press at (320,240), hit ack two cycles later
        mouse_left_in = 1'b1;
        step();
        chk("lat_req_n", 32'(shot_req), 0);
        step();
        chk("lat_req_n1", 32'(shot_req), 1);
        chk("shot_x", 32'(shot_x), 320);
        chk("shot_y", 32'(shot_y), 240);
        chk("ammo_2", 32'(ammo), 2);
        xpos_in = 10'd5;
        step();
        chk("x_stable", 32'(shot_x), 320);
        hit_ack = 1'b1;
        hit_in = 1'b1;
        step();
        hit_ack = 1'b0;
        hit_in = 1'b0;
        chk("hit_pulse", 32'(hit_pulse), 1);
        chk("hit_nomiss", 32'(miss_pulse), 0);
        chk("req_drop", 32'(shot_req), 0);
        step();
        chk("hit_once", 32'(hit_pulse), 0);
        chk("cd_busy", 32'(busy), 1);
        ticks(9);
        chk("cd_9", 32'(busy), 1);
        ticks(1);
        chk("cd_10", 32'(busy), 0);
        step();
        step();
        chk("held_nofire", 32'(shot_req), 0);
        chk("held_ammo", 32'(ammo), 2);

        // shot 2: timeout miss
        xpos_in = 10'd100;
        ypos_in = 10'd50;
        press_fire();
        chk("s2_req", 32'(shot_req), 1);
        chk("s2_ammo", 32'(ammo), 1);
        reload_in = 1'b1;
        step();
        reload_in = 1'b0;
        chk("reload_req_ign", 32'(ammo), 1);
        ticks(1);
        chk("to_1tick", 32'(shot_req), 1);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        chk("miss_pulse", 32'(miss_pulse), 1);
        chk("miss_nohit", 32'(hit_pulse), 0);
        chk("miss_req_drop", 32'(shot_req), 0);
        step();
        chk("miss_once", 32'(miss_pulse), 0);
        chk("miss_cd", 32'(busy), 1);
        hit_ack = 1'b1;
        hit_in = 1'b1;
        step();
        hit_ack = 1'b0;
        hit_in = 1'b0;
        chk("ack_cd_ign", 32'(hit_pulse), 0);
        mouse_left_in = 1'b0;
        ticks(2);
        mouse_left_in = 1'b1;
        ticks(8);
        chk("cd_press_ign", 32'(shot_req), 0);
        chk("cd_press_ammo", 32'(ammo), 1);

        // shot 3: ack and final timeout tick together
        press_fire();
        chk("s3_req", 32'(shot_req), 1);
        chk("s3_ammo", 32'(ammo), 0);
        ticks(1);
        frame_tick = 1'b1;
        hit_ack = 1'b1;
        hit_in = 1'b1;
        step();
        frame_tick = 1'b0;
        hit_ack = 1'b0;
        hit_in = 1'b0;
        chk("race_hit", 32'(hit_pulse), 1);
        chk("race_nomiss", 32'(miss_pulse), 0);
        step();
        ticks(10);
        chk("s3_idle", 32'(busy), 0);

        // fourth press with no ammo
        press_fire();
        step();
        chk("empty_noreq", 32'(shot_req), 0);
        chk("empty_busy", 32'(busy), 0);
        chk("empty_ammo", 32'(ammo), 0);

        // reload and press edge in the same cycle
        mouse_left_in = 1'b0;
        step();
        step();
        mouse_left_in = 1'b1;
        step();
        reload_in = 1'b1;
        step();
        reload_in = 1'b0;
        chk("reload_ammo", 32'(ammo), 3);
        chk("reload_wins", 32'(shot_req), 0);
        step();
        chk("reload_wins2", 32'(shot_req), 0);

        // async reset mid-REQ, button held through release
        xpos_in = 10'd700;
        press_fire();
        chk("s5_req", 32'(shot_req), 1);
        chk("s5_ammo", 32'(ammo), 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", 32'(shot_req), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ammo", 32'(ammo), 3);
        chk("arst_x", 32'(shot_x), 0);
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("held_rst_nofire", 32'(shot_req), 0);
        press_fire();
        chk("after_rst_fire", 32'(shot_req), 1);
        chk("after_rst_x", 32'(shot_x), 700);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mouse_shot_ctrl.md
MOUSE_SHOT_CTRL -- requirements
Module: mouse_shot_ctrl

Interface
REQ-001 Parameter AMMO_MAX, default 3: shots available after reload.
REQ-002 Parameter COOLDOWN_FRAMES, default 10: frame_tick pulses spent in COOLDOWN after each shot.
REQ-003 Parameter TIMEOUT_FRAMES, default 2: frame_tick pulses in REQ before a missing ack is treated as a miss.
REQ-004 clk  in  1  system clock; all flops on posedge clk.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 xpos_in  in  10  synchronized cursor x.
REQ-007 ypos_in  in  10  synchronized cursor y.
REQ-008 mouse_left_in  in  1  synchronized left button level.
REQ-009 frame_tick  in  1  one-cycle pulse per video frame.
REQ-010 reload_in  in  1  one-cycle pulse: refill ammo.
REQ-011 hit_ack  in  1  one-cycle pulse from hit detector: result valid.
REQ-012 hit_in  in  1  hit result, valid only with hit_ack.
REQ-013 shot_req  out  1  request to hit detector, held until ack or timeout.
REQ-014 shot_x  out  10  latched shot x, stable while shot_req=1.
REQ-015 shot_y  out  10  latched shot y, stable while shot_req=1.
REQ-016 hit_pulse  out  1  one-cycle pulse: shot hit.
REQ-017 miss_pulse  out  1  one-cycle pulse: shot missed or timed out.
REQ-018 ammo  out  2  remaining shots.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 Block SHALL register mouse_left_in once and detect a press as current=1, previous=0; a held button SHALL never re-trigger.
REQ-021 FSM states SHALL be IDLE, REQ, RESULT, COOLDOWN.
REQ-022 IDLE: press with ammo>0 SHALL, on that edge, latch xpos_in/ypos_in into shot_x/shot_y, decrement ammo, go to REQ.
REQ-023 IDLE: press with ammo=0 SHALL be ignored (no state change, no pulse).
REQ-024 REQ: shot_req=1; hit_ack SHALL capture hit_in and go to RESULT next cycle.
REQ-025 REQ: frame counter SHALL count frame_tick; on reaching TIMEOUT_FRAMES without ack, go to RESULT with result=miss.
REQ-026 hit_ack and final timeout frame_tick in the same cycle: ack SHALL win (hit_in used).
REQ-027 RESULT: exactly one of hit_pulse/miss_pulse high for one cycle, then COOLDOWN with frame counter cleared.
REQ-028 COOLDOWN: count frame_tick; after COOLDOWN_FRAMES ticks return to IDLE; presses during COOLDOWN SHALL be discarded.
REQ-029 hit_ack outside REQ SHALL be ignored.
REQ-030 reload_in SHALL set ammo=AMMO_MAX only in IDLE; ignored elsewhere.
REQ-031 reload_in and press in the same IDLE cycle: reload wins, press ignored, ammo=AMMO_MAX.
REQ-032 Latency: press edge at cycle N -> shot_req=1 at N+1 (registered edge detect adds one cycle from mouse_left_in to decision).
REQ-033 ammo SHALL never wrap below 0 or exceed AMMO_MAX.
REQ-034 Counters SHALL be wide enough for max(COOLDOWN_FRAMES, TIMEOUT_FRAMES) without overflow.

Reset
REQ-035 rst SHALL force IDLE, ammo=AMMO_MAX, shot_req=0, shot_x=0, shot_y=0, hit_pulse=0, miss_pulse=0, busy=0, counters=0, button history=0, asynchronously, including mid-REQ or mid-COOLDOWN.
REQ-036 Button held through reset release SHALL NOT fire until released and pressed again.

Structure
REQ-037 State enum and AMMO_MAX default SHALL live in shared package game_pkg.
REQ-038 Single module; no sub-modules; edge detector inline.

Verification
REQ-039 Reset, press at (320,240), ack with hit_in=1 two cycles later -> shot_x=320, shot_y=240, hit_pulse one cycle, ammo 3->2.
REQ-040 Press, no ack, two frame_ticks -> miss_pulse one cycle, shot_req drops, COOLDOWN entered.
REQ-041 Three shots, fourth press -> ammo=0, no shot_req; reload_in in IDLE -> ammo=3.
REQ-042 Button held through full shot and COOLDOWN -> exactly one shot; release+press -> second shot.
REQ-043 Ack and timeout tick same cycle with hit_in=1 -> hit_pulse, no miss_pulse.
REQ-044 rst asserted during REQ -> outputs at reset values immediately, ammo=3.
